// File: rtl/vga_text_pkg.sv
// Shared geometry constants and the sideband bundle for the text-mode pixel path.
package vga_text_pkg;

  localparam int CHAR_W         = 8;
  localparam int CHAR_H         = 16;
  localparam int GLYPH_ROW_BITS = 4;
  localparam int XBIT_W         = $clog2(CHAR_W);
  localparam int FONT_ADDR_W    = 12;
  localparam int VRAM_ADDR_W    = 12;
  localparam int PIPE_LAT       = 4;

  // Everything that must travel alongside a pixel while its glyph is fetched.
  typedef struct packed {
    logic              visible;
    logic              hsync;
    logic              vsync;
    logic [XBIT_W-1:0] xbit;
    logic              cursor_hit;
  } sideband_t;

endpackage

// File: rtl/text_cursor_blink.sv
// Cursor blink timer: counts frame starts and toggles the visible phase
// every BLINK_FRAMES frames.
module text_cursor_blink
  import vga_text_pkg::*;
#(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_s1,
  output logic phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             vsync_prev_q, vsync_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             frame_start;

  // Detect a frame start on the registered vsync and advance the blink count.
  always_comb begin
    vsync_prev_d = vsync_s1;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    frame_start  = vsync_s1 & ~vsync_prev_q;
    if (frame_start) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_q <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: raster position -> text buffer read -> font ROM
// read -> glyph bit, with sidebands delayed to stay aligned and a blinking
// block cursor XORed over the glyph.
module text_pixel_gen
  import vga_text_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        visible_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [11:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pixel_on,
  output logic        visible_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  // The text buffer must fit the address space and glyph rows must fill the row index.
  if ((COLS * ROWS > (1 << VRAM_ADDR_W)) || (CHAR_H != (1 << GLYPH_ROW_BITS))) begin : g_bad_cfg
    $error("text_pixel_gen: unsupported text geometry");
  end

  logic [6:0]                col;
  logic [4:0]                row;
  logic                      phase;
  logic                      unused_vcount_msb;
  sideband_t                 sb_in;
  sideband_t                 stage4;

  logic [VRAM_ADDR_W-1:0]    vram_addr_q, vram_addr_d;
  logic [FONT_ADDR_W-1:0]    font_addr_q, font_addr_d;
  logic [GLYPH_ROW_BITS-1:0] glyph_row_q [2];
  logic [GLYPH_ROW_BITS-1:0] glyph_row_d [2];
  sideband_t                 pipe_q [PIPE_LAT];
  sideband_t                 pipe_d [PIPE_LAT];
  logic                      pixel_on_q, pixel_on_d;
  logic                      visible_out_q, visible_out_d;
  logic                      hsync_out_q, hsync_out_d;
  logic                      vsync_out_q, vsync_out_d;

  // Rows stop at 29, so the top vcount bit never selects anything.
  assign unused_vcount_msb = vcount[9];

  // S1 decode: cell position, text buffer address and cursor match.
  always_comb begin
    col              = hcount[9:XBIT_W];
    row              = vcount[GLYPH_ROW_BITS +: 5];
    sb_in.visible    = visible_in;
    sb_in.hsync      = hsync_in;
    sb_in.vsync      = vsync_in;
    sb_in.xbit       = hcount[XBIT_W-1:0];
    sb_in.cursor_hit = cursor_en & phase & (col == cursor_col) & (row == cursor_row);
    vram_addr_d      = '0;
    if (visible_in) begin
      vram_addr_d = VRAM_ADDR_W'(row) * VRAM_ADDR_W'(COLS) + VRAM_ADDR_W'(col);
    end
  end

  // Pipeline advance: sideband shift register, glyph row carry, font address.
  always_comb begin
    pipe_d[0] = sb_in;
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    glyph_row_d[0] = vcount[GLYPH_ROW_BITS-1:0];
    glyph_row_d[1] = glyph_row_q[0];
    font_addr_d    = {vram_data, glyph_row_q[1]};
  end

  // Output stage: pick the glyph bit for this pixel and apply the cursor.
  always_comb begin
    stage4        = pipe_q[PIPE_LAT-1];
    pixel_on_d    = stage4.visible & (font_data[3'd7 - stage4.xbit] ^ stage4.cursor_hit);
    visible_out_d = stage4.visible;
    hsync_out_d   = stage4.hsync;
    vsync_out_d   = stage4.vsync;
  end

  // All pipeline and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_addr_q    <= '0;
      font_addr_q    <= '0;
      glyph_row_q[0] <= '0;
      glyph_row_q[1] <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      pixel_on_q     <= 1'b0;
      visible_out_q  <= 1'b0;
      hsync_out_q    <= 1'b0;
      vsync_out_q    <= 1'b0;
    end else begin
      vram_addr_q    <= vram_addr_d;
      font_addr_q    <= font_addr_d;
      glyph_row_q[0] <= glyph_row_d[0];
      glyph_row_q[1] <= glyph_row_d[1];
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      pixel_on_q     <= pixel_on_d;
      visible_out_q  <= visible_out_d;
      hsync_out_q    <= hsync_out_d;
      vsync_out_q    <= vsync_out_d;
    end
  end

  text_cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk      (clk),
    .rst      (rst),
    .vsync_s1 (pipe_q[0].vsync),
    .phase    (phase)
  );

  assign vram_addr   = vram_addr_q;
  assign font_addr   = font_addr_q;
  assign pixel_on    = pixel_on_q;
  assign visible_out = visible_out_q;
  assign hsync_out   = hsync_out_q;
  assign vsync_out   = vsync_out_q;

endmodule
